// File: rtl/madd3_pkg.sv
// madd3_pkg: shared constants and types for the add-3 (double-dabble)
// correction cell.
//   DIGIT_W        - width of one BCD digit lane
//   ADD3_THRESHOLD - lane values at or above this get the +3 correction
//   ADD3_OFFSET    - correction amount
//   BCD_MAX        - largest legal BCD digit (used by the optional check)
//   digit_t        - one 4-bit digit lane
package madd3_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t ADD3_THRESHOLD = 4'd5;
    localparam digit_t ADD3_OFFSET    = 4'd3;
    localparam digit_t BCD_MAX        = 4'd9;

endpackage : madd3_pkg

// File: rtl/madd3_cell.sv
// madd3_cell: purely combinational single-lane add-3 correction.
//   v       in   digit to correct
//   f       out  v + 3 (mod 16) when v >= 5, otherwise v
//   adj     out  1 when the +3 correction was applied
//   bcd_err out  1 when v is not a legal BCD digit (> 9)
//                (present only when MADD3_BCD_CHECK_EN is defined)
module madd3_cell
    import madd3_pkg::*;
(
    input  digit_t v,
    output digit_t f,
    output logic   adj
`ifdef MADD3_BCD_CHECK_EN
    ,
    output logic   bcd_err
`endif
);

    always_comb begin
        adj = (v >= ADD3_THRESHOLD);
        // 4-bit sum: 13..15 wrap to 0..2, the carry is intentionally dropped.
        f   = adj ? digit_t'(v + ADD3_OFFSET) : v;
    end

`ifdef MADD3_BCD_CHECK_EN
    assign bcd_err = (v > BCD_MAX);
`endif

endmodule : madd3_cell

// File: rtl/madd3.sv
// madd3: registered add-3 correction stage for a binary-to-BCD converter.
// LANES independent 4-bit digits are corrected in parallel with one cycle
// of latency; outputs come straight from registers.
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset (priority over in_valid)
//   in_valid  in   x is valid this cycle
//   x         in   input digits, lane i = x[4i+3:4i]
//   out_valid out  y/adj are fresh this cycle
//   y         out  corrected digits, lane i = y[4i+3:4i]
//   adj       out  bit i set when lane i got +3
//   bcd_err   out  bit i set when lane i input was > 9
//                  (present only when MADD3_BCD_CHECK_EN is defined)
// When in_valid is low, y/adj/bcd_err hold and out_valid drops.
module madd3
    import madd3_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [4*LANES-1:0]   x,
    output logic                 out_valid,
    output logic [4*LANES-1:0]   y,
    output logic [LANES-1:0]     adj
`ifdef MADD3_BCD_CHECK_EN
    ,
    output logic [LANES-1:0]     bcd_err
`endif
);

    logic [4*LANES-1:0] y_next;
    logic [LANES-1:0]   adj_next;
    logic [4*LANES-1:0] y_reg;
    logic [LANES-1:0]   adj_reg;
    logic               out_valid_reg;

`ifdef MADD3_BCD_CHECK_EN
    logic [LANES-1:0]   bcd_err_next;
    logic [LANES-1:0]   bcd_err_reg;
`endif

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            madd3_cell u_cell (
                .v       (x[gi*DIGIT_W +: DIGIT_W]),
                .f       (y_next[gi*DIGIT_W +: DIGIT_W]),
                .adj     (adj_next[gi])
`ifdef MADD3_BCD_CHECK_EN
                ,
                .bcd_err (bcd_err_next[gi])
`endif
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_reg         <= '0;
            adj_reg       <= '0;
            out_valid_reg <= 1'b0;
`ifdef MADD3_BCD_CHECK_EN
            bcd_err_reg   <= '0;
`endif
        end else begin
            out_valid_reg <= in_valid;
            // Data registers only load on a valid beat so idle cycles hold them.
            if (in_valid) begin
                y_reg       <= y_next;
                adj_reg     <= adj_next;
`ifdef MADD3_BCD_CHECK_EN
                bcd_err_reg <= bcd_err_next;
`endif
            end
        end
    end

    assign y         = y_reg;
    assign adj       = adj_reg;
    assign out_valid = out_valid_reg;
`ifdef MADD3_BCD_CHECK_EN
    assign bcd_err   = bcd_err_reg;
`endif

endmodule : madd3

// File: tb/tb_madd3.sv
// tb_madd3: self-checking bench for madd3. Drives a LANES=1 and a LANES=4
// instance from a table of directed vectors, hand-written reset/hold
// sequences and a randomized run checked against a behavioural model.
module tb_madd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid1, in_valid4;
    logic [3:0]  x1;
    logic [15:0] x4;
    logic        out_valid1, out_valid4;
    logic [3:0]  y1;
    logic [15:0] y4;
    logic        adj1;
    logic [3:0]  adj4;
`ifdef MADD3_BCD_CHECK_EN
    logic        bcd_err1;
    logic [3:0]  bcd_err4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    madd3 #(.LANES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .x         (x1),
        .out_valid (out_valid1),
        .y         (y1),
        .adj       (adj1)
`ifdef MADD3_BCD_CHECK_EN
        ,
        .bcd_err   (bcd_err1)
`endif
    );

    madd3 #(.LANES(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .x         (x4),
        .out_valid (out_valid4),
        .y         (y4),
        .adj       (adj4)
`ifdef MADD3_BCD_CHECK_EN
        ,
        .bcd_err   (bcd_err4)
`endif
    );

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       adj;
        logic       err;
    } vec1_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  adj;
        logic [3:0]  err;
    } vec4_t;

    vec1_t tbl1 [16];
    vec4_t tbl4 [2];

    // Reference digit function from the add-3 rule, plain integer arithmetic.
    function automatic logic [3:0] ref_f(input int v);
        int r;
        r = (v >= 5) ? (v + 3) % 16 : v;
        return r[3:0];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] m_y;
    logic [3:0]  m_adj, m_err;
    logic        m_ov;

    initial begin
        // Exhaustive single-lane table: y, adj and bcd_err for every value.
        tbl1[0]  = '{4'h0, 4'h0, 1'b0, 1'b0};
        tbl1[1]  = '{4'h1, 4'h1, 1'b0, 1'b0};
        tbl1[2]  = '{4'h2, 4'h2, 1'b0, 1'b0};
        tbl1[3]  = '{4'h3, 4'h3, 1'b0, 1'b0};
        tbl1[4]  = '{4'h4, 4'h4, 1'b0, 1'b0};
        tbl1[5]  = '{4'h5, 4'h8, 1'b1, 1'b0};
        tbl1[6]  = '{4'h6, 4'h9, 1'b1, 1'b0};
        tbl1[7]  = '{4'h7, 4'hA, 1'b1, 1'b0};
        tbl1[8]  = '{4'h8, 4'hB, 1'b1, 1'b0};
        tbl1[9]  = '{4'h9, 4'hC, 1'b1, 1'b0};
        tbl1[10] = '{4'hA, 4'hD, 1'b1, 1'b1};
        tbl1[11] = '{4'hB, 4'hE, 1'b1, 1'b1};
        tbl1[12] = '{4'hC, 4'hF, 1'b1, 1'b1};
        tbl1[13] = '{4'hD, 4'h0, 1'b1, 1'b1};
        tbl1[14] = '{4'hE, 4'h1, 1'b1, 1'b1};
        tbl1[15] = '{4'hF, 4'h2, 1'b1, 1'b1};
        tbl4[0]  = '{16'h9540, 16'hC840, 4'b1100, 4'b0000};
        tbl4[1]  = '{16'hFD50, 16'h2080, 4'b1110, 4'b1100};

        rst_n = 1'b0; in_valid1 = 1'b1; x1 = 4'h7; in_valid4 = 1'b1; x4 = 16'h7777;

        // Reset held for two edges with a valid input present.
        for (int i = 0; i < 2; i++) begin
            tick();
            $display("txn reset cycle %0d: y1=%h adj1=%b ov1=%b", i, y1, adj1, out_valid1);
            check("reset_y1", {12'h0, y1}, 16'h0);
            check("reset_adj1", {15'h0, adj1}, 16'h0);
            check("reset_ov1", {15'h0, out_valid1}, 16'h0);
            check("reset_y4", y4, 16'h0);
            check("reset_ov4", {15'h0, out_valid4}, 16'h0);
        end
        rst_n = 1'b1;
        tick();
        $display("txn release: x1=7 y1=%h adj1=%b ov1=%b", y1, adj1, out_valid1);
        check("release_y1", {12'h0, y1}, 16'h000A);
        check("release_adj1", {15'h0, adj1}, 16'h1);
        check("release_ov1", {15'h0, out_valid1}, 16'h1);

        // Sweep 0..15 on consecutive cycles.
        in_valid4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            x1 = tbl1[i].x;
            tick();
            $display("txn sweep x1=%h y1=%h adj1=%b ov1=%b", tbl1[i].x, y1, adj1, out_valid1);
            check("sweep_y", {12'h0, y1}, {12'h0, tbl1[i].y});
            check("sweep_adj", {15'h0, adj1}, {15'h0, tbl1[i].adj});
            check("sweep_ov", {15'h0, out_valid1}, 16'h1);
`ifdef MADD3_BCD_CHECK_EN
            check("sweep_bcd_err", {15'h0, bcd_err1}, {15'h0, tbl1[i].err});
`endif
        end

        // Hold: one valid beat then three idle cycles with a different x.
        x1 = 4'h6;
        tick();
        check("hold_first_y", {12'h0, y1}, 16'h9);
        in_valid1 = 1'b0; x1 = 4'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("txn hold idle %0d: y1=%h adj1=%b ov1=%b", i, y1, adj1, out_valid1);
            check("hold_y", {12'h0, y1}, 16'h9);
            check("hold_adj", {15'h0, adj1}, 16'h1);
            check("hold_ov", {15'h0, out_valid1}, 16'h0);
        end

        // Multi-lane vectors.
        in_valid4 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            x4 = tbl4[i].x;
            tick();
            $display("txn lanes x4=%h y4=%h adj4=%b ov4=%b", tbl4[i].x, y4, adj4, out_valid4);
            check("lanes_y", y4, tbl4[i].y);
            check("lanes_adj", {12'h0, adj4}, {12'h0, tbl4[i].adj});
            check("lanes_ov", {15'h0, out_valid4}, 16'h1);
`ifdef MADD3_BCD_CHECK_EN
            check("lanes_bcd_err", {12'h0, bcd_err4}, {12'h0, tbl4[i].err});
`endif
        end
        in_valid4 = 1'b0;

        // Reset mid-stream right after x=5 is accepted.
        in_valid1 = 1'b1; x1 = 4'h5;
        tick();
        check("midrst_pending_y", {12'h0, y1}, 16'h8);
        rst_n = 1'b0;
        tick();
        $display("txn mid-stream reset: y1=%h adj1=%b ov1=%b", y1, adj1, out_valid1);
        check("midrst_y", {12'h0, y1}, 16'h0);
        check("midrst_adj", {15'h0, adj1}, 16'h0);
        check("midrst_ov", {15'h0, out_valid1}, 16'h0);
        in_valid1 = 1'b0;
        rst_n = 1'b1;
        tick();

        // Randomized run on the 4-lane instance against the model.
        m_y = '0; m_adj = '0; m_err = '0; m_ov = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            in_valid4 = ($urandom_range(0, 3) != 0);
            x4        = 16'($urandom);
            if (!rst_n) begin
                m_y = '0; m_adj = '0; m_err = '0; m_ov = 1'b0;
            end else begin
                m_ov = in_valid4;
                if (in_valid4) begin
                    for (int l = 0; l < 4; l++) begin
                        int v;
                        v = int'(x4[4*l +: 4]);
                        m_y[4*l +: 4] = ref_f(v);
                        m_adj[l]      = (v >= 5);
                        m_err[l]      = (v > 9);
                    end
                end
            end
            tick();
            $display("txn rand %0d rst_n=%b iv=%b x4=%h y4=%h adj4=%b ov4=%b",
                     i, rst_n, in_valid4, x4, y4, adj4, out_valid4);
            check("rand_y", y4, m_y);
            check("rand_adj", {12'h0, adj4}, {12'h0, m_adj});
            check("rand_ov", {15'h0, out_valid4}, {15'h0, m_ov});
`ifdef MADD3_BCD_CHECK_EN
            check("rand_bcd_err", {12'h0, bcd_err4}, {12'h0, m_err});
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_madd3
